// File: rtl/ext_bus16_if.sv
// Bundle of the user request/response handshake and the external SRAM-style bus pins
// for ext_bus16_ctrl; "master" is the controller side, "slave" the user/pad side.
interface ext_bus16_if #(
    parameter int ADDR_W = 20
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              done;
    logic              rsp_valid;
    logic [15:0]       rsp_rdata;
    logic [15:0]       bus_o;
    logic              bus_t;
    logic [15:0]       bus_i;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ce_n;
    logic              mem_we_n;
    logic              mem_oe_n;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_i,
        output req_ready, done, rsp_valid, rsp_rdata, bus_o, bus_t,
               mem_addr, mem_ce_n, mem_we_n, mem_oe_n
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_i,
        input  req_ready, done, rsp_valid, rsp_rdata, bus_o, bus_t,
               mem_addr, mem_ce_n, mem_we_n, mem_oe_n
    );
endinterface

// File: rtl/ext_bus16_ctrl.sv
// Single-word async-SRAM sequencer driving a 16-bit IOBUF (bus_o/bus_t/bus_i) with CE#/WE#/OE#.
// Define EXT_BUS16_INREG_EN to register bus_i in a pad flop first (adds one read-wait cycle).
module ext_bus16_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int WR_CYCLES   = 2,
    parameter int RD_CYCLES   = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic         clk,
    input  logic         reset,
    ext_bus16_if.master  bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_SETUP  = 3'd1;
    localparam logic [2:0] S_WR_PULSE  = 3'd2;
    localparam logic [2:0] S_WR_HOLD   = 3'd3;
    localparam logic [2:0] S_RD_WAIT   = 3'd4;
    localparam logic [2:0] S_RD_SAMPLE = 3'd5;
    localparam logic [2:0] S_TURN      = 3'd6;

    logic [15:0] rd_sample;
`ifdef EXT_BUS16_INREG_EN
    localparam int RD_LEN = RD_CYCLES + 1;
    logic [15:0] bus_in_q;

    always_ff @(posedge clk) begin
        bus_in_q <= bus.bus_i;
    end
    assign rd_sample = bus_in_q;
`else
    localparam int RD_LEN = RD_CYCLES;
    assign rd_sample = bus.bus_i;
`endif

    localparam int CNT_MAX0 = (WR_CYCLES > RD_LEN) ? WR_CYCLES : RD_LEN;
    localparam int CNT_MAX  = (CNT_MAX0 > TURN_CYCLES) ? CNT_MAX0 : TURN_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              bus_t_q, bus_t_d;
    logic              ce_n_q, ce_n_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic [15:0]       rsp_rdata_q;
    logic [15:0]       bus_o_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              accept;

    assign accept = bus.req_valid && ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.req_write) begin
                        state_d = S_WR_SETUP;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = CNT_W'(RD_LEN - 1);
                    end
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = CNT_W'(WR_CYCLES - 1);
            end
            S_WR_PULSE: begin
                if (cnt_q == '0) state_d = S_WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WR_HOLD: state_d = S_IDLE;
            S_RD_WAIT: begin
                if (cnt_q == '0) state_d = S_RD_SAMPLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RD_SAMPLE: begin
                if (TURN_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_TURN;
                    cnt_d   = CNT_W'(TURN_CYCLES - 1);
                end
            end
            S_TURN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they line up with the state itself.
        // Ready skips the first IDLE cycle after any transfer, giving one idle bus cycle.
        ready_d     = (state_q == S_IDLE) && (state_d == S_IDLE);
        done_d      = (state_d == S_WR_HOLD) || (state_q == S_RD_SAMPLE);
        rsp_valid_d = (state_q == S_RD_SAMPLE);
        bus_t_d     = !(state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
        ce_n_d      = (state_d == S_IDLE) || (state_d == S_TURN);
        we_n_d      = (state_d != S_WR_PULSE);
        oe_n_d      = !(state_d inside {S_RD_WAIT, S_RD_SAMPLE});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            bus_t_q     <= 1'b1;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            rsp_rdata_q <= '0;
            bus_o_q     <= '0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            bus_t_q     <= bus_t_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            if (accept) begin
                mem_addr_q <= bus.req_addr;
                if (bus.req_write) bus_o_q <= bus.req_wdata;
            end
            if (state_q == S_RD_SAMPLE) rsp_rdata_q <= rd_sample;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.bus_o     = bus_o_q;
    assign bus.bus_t     = bus_t_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_we_n  = we_n_q;
    assign bus.mem_oe_n  = oe_n_q;
endmodule

// File: tb/tb_ext_bus16_ctrl.sv
// Scoreboard bench for ext_bus16_ctrl: an SRAM pad model, a dictionary reference memory,
// and a negedge monitor checking done/rsp timing, data, strobe widths and bus turnaround.
module tb_ext_bus16_ctrl;
    localparam int ADDR_W      = 20;
    localparam int WR_CYCLES   = 2;
    localparam int RD_CYCLES   = 2;
    localparam int TURN_CYCLES = 1;
`ifdef EXT_BUS16_INREG_EN
    localparam int RD_LEN = RD_CYCLES + 1;
`else
    localparam int RD_LEN = RD_CYCLES;
`endif

    logic clk;
    logic reset;
    int   cyc;
    int   passed;
    int   total;
    bit   aborting;

    ext_bus16_if #(.ADDR_W(ADDR_W)) bus ();

    ext_bus16_ctrl #(
        .ADDR_W(ADDR_W), .WR_CYCLES(WR_CYCLES),
        .RD_CYCLES(RD_CYCLES), .TURN_CYCLES(TURN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit          rd;
        int          addr;
        logic [15:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] sram [int];
    logic [15:0] refm [int];
    int          exp_ready_low;

    function automatic logic [15:0] sram_get(input int a);
        return sram.exists(a) ? sram[a] : 16'h0000;
    endfunction

    function automatic logic [15:0] ref_get(input int a);
        return refm.exists(a) ? refm[a] : 16'h0000;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // External SRAM: writes commit on WE# rising, reads drive the pads while CE#/OE# are low.
    always @(posedge bus.mem_we_n) begin
        if (!aborting && !bus.mem_ce_n && !bus.bus_t) sram[int'(bus.mem_addr)] = bus.bus_o;
    end

    always @(negedge clk) begin
        bus.bus_i = (!bus.mem_ce_n && !bus.mem_oe_n && bus.bus_t) ?
                    sram_get(int'(bus.mem_addr)) : 16'h5A5A;
    end

    int bt_run, we_run, rdy_run, gap;
    bit skip_rdy, track, prev_oe;

    always @(negedge clk) begin
        if (reset) begin
            bt_run = 0; we_run = 0; rdy_run = 0;
            skip_rdy = 1'b1; track = 1'b0; prev_oe = 1'b1;
        end else begin
            check("no_contention",
                  longint'((!bus.bus_t && !bus.mem_oe_n) || (!bus.mem_we_n && bus.bus_t)), 0);

            if (bus.done || bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_done", longint'(bus.done | bus.rsp_valid), 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", cyc - e.acc, e.lat);
                    check("done_pulse", bus.done, 1);
                    check("rsp_valid", bus.rsp_valid, e.rd);
                    check("mem_addr", bus.mem_addr, e.addr);
                    if (e.rd) check("rsp_rdata", bus.rsp_rdata, e.data);
                    else      check("sram_write", sram_get(e.addr), e.data);
                end
            end

            if (!bus.bus_t) bt_run++;
            else if (bt_run != 0) begin
                check("bus_t_low_width", bt_run, WR_CYCLES + 2);
                bt_run = 0;
            end
            if (!bus.mem_we_n) we_run++;
            else if (we_run != 0) begin
                check("we_n_low_width", we_run, WR_CYCLES);
                we_run = 0;
            end

            if (!bus.req_ready) rdy_run++;
            else if (rdy_run != 0) begin
                if (!skip_rdy) check("ready_low_len", rdy_run, exp_ready_low);
                skip_rdy = 1'b0;
                rdy_run  = 0;
            end

            if (!prev_oe && bus.mem_oe_n) begin
                track = 1'b1;
                gap   = 0;
            end
            if (track) begin
                if (!bus.bus_t) begin
                    check("turnaround_gap",
                          (gap >= TURN_CYCLES + 1) ? TURN_CYCLES + 1 : gap, TURN_CYCLES + 1);
                    track = 1'b0;
                end else if (!bus.mem_oe_n) track = 1'b0;
                else gap++;
            end
            prev_oe = bus.mem_oe_n;
        end
    end

    // Accept happens on the posedge after a negedge where valid and ready are both high.
    // Response latency is counted in edges from that accept edge to the edge raising done.
    task automatic issue(input bit w, input int a, input logic [15:0] d);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = ADDR_W'(a);
        bus.req_wdata = d;
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", bus.req_ready, 1);
            bus.req_valid = 1'b0;
            return;
        end
        e.rd   = !w;
        e.addr = a;
        e.data = w ? d : ref_get(a);
        e.acc  = cyc + 1;
        e.lat  = w ? WR_CYCLES + 1 : RD_LEN + 1;
        sb.push_back(e);
        if (w) refm[a] = d;
        exp_ready_low = w ? WR_CYCLES + 3 : RD_LEN + 2 + TURN_CYCLES;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = ADDR_W'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        passed = 0; total = 0; aborting = 1'b1; exp_ready_low = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.bus_i = 16'h5A5A;

        repeat (3) @(negedge clk);
        check("rst_bus_t", bus.bus_t, 1);
        check("rst_ce_n", bus.mem_ce_n, 1);
        check("rst_we_n", bus.mem_we_n, 1);
        check("rst_oe_n", bus.mem_oe_n, 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_bus_o", bus.bus_o, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        reset = 1'b0;
        #1 check("ready_before_edge", bus.req_ready, 0);
        @(negedge clk);
        check("ready_after_edge", bus.req_ready, 1);
        aborting = 1'b0;

        issue(1'b1, 'h12345, 16'hBEEF);
        drain();
        check("sram_beef", sram_get('h12345), 16'hBEEF);
        issue(1'b0, 'h12345, 16'h0000);
        drain();
        check("read_beef", bus.rsp_rdata, 16'hBEEF);

        issue(1'b0, 'h12345, 16'h0000);
        issue(1'b1, 'h00007, 16'h55AA);
        drain();

        // Abort a write in the middle of its WE# pulse.
        begin
            int n;
            issue(1'b1, 'hABCDE, 16'h1234);
            n = 0;
            while (bus.mem_we_n && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("reached_we_pulse", bus.mem_we_n, 0);
            #2;
            aborting = 1'b1;
            reset    = 1'b1;
            #1;
            check("abort_we_n", bus.mem_we_n, 1);
            check("abort_bus_t", bus.bus_t, 1);
            check("abort_ce_n", bus.mem_ce_n, 1);
            sb.delete();
            refm.delete('hABCDE);
            repeat (2) @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            aborting = 1'b0;
            check("abort_ready_back", bus.req_ready, 1);
        end
        issue(1'b1, 'h00003, 16'hC0DE);
        drain();
        issue(1'b0, 'h00003, 16'h0000);
        drain();

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 15), 16'($urandom));
        end
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
